// File: rtl/uart_rsa_pkg.sv
// Shared constants and encodings for the UART-to-RSA byte path.
package uart_rsa_pkg;

    localparam int BYTE_W           = 8;
    localparam int WORD_BYTES_DEF   = 4;
    localparam int CLKS_PER_BIT     = 87;
    // One full character is 10 bit-times; allow a word's worth of character gaps.
    localparam int TIMEOUT_CLKS_DEF = CLKS_PER_BIT * 10 * WORD_BYTES_DEF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } coll_state_e;

endpackage

// File: rtl/uart_idle_timer.sv
// Clearable, enable-gated down-counter; strobes o_Expire on the cycle the count runs out.
module uart_idle_timer #(
    parameter int TIMEOUT_CLKS = 3480
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Enable,
    input  logic i_Clear,
    output logic o_Expire
);

    localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_Clear)
            count_d = LOAD;
        else if (i_Enable && count_q != '0)
            count_d = count_q - 1'b1;
    end

    // A clear on the expiry cycle suppresses the strobe: the new byte wins.
    assign o_Expire = i_Enable && !i_Clear && (count_q == '0);

    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs uart_rx bytes MSB-first into words with a one-deep output register,
// overrun flag and inter-byte timeout.
module uart_word_assembler
    import uart_rsa_pkg::*;
#(
    parameter int WORD_BYTES   = WORD_BYTES_DEF,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic                         i_Rx_DV,
    input  logic [BYTE_W-1:0]            i_Rx_Byte,
    output logic [WORD_BYTES*BYTE_W-1:0] o_Word,
    output logic                         o_Word_Valid,
    input  logic                         i_Word_Ready,
    output logic                         o_Overrun,
    output logic                         o_Timeout,
    input  logic                         i_Clear_Err
);

    localparam int W     = WORD_BYTES * BYTE_W;
    localparam int CNT_W = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

    coll_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [W-1:0]     word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             tmo_q, tmo_d;

    logic             expire;
    logic             final_byte;
    logic             out_free;
    logic             collecting;
    logic [W-1:0]     completed;

    assign final_byte = i_Rx_DV && (cnt_q == LAST);
    assign out_free   = !valid_q || i_Word_Ready;
    assign completed  = {shift_q[W-BYTE_W-1:0], i_Rx_Byte};

    uart_idle_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_idle_timer (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Enable (collecting),
        .i_Clear  (i_Rx_DV),
        .o_Expire (expire)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_Rx_DV) begin
            if (final_byte) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ST_COLLECT;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (expire) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        collecting = (state_q == ST_COLLECT);
        shift_d    = i_Rx_DV ? completed : shift_q;
        word_d     = word_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        tmo_d      = expire;
        if (valid_q && i_Word_Ready)
            valid_d = 1'b0;
        if (i_Clear_Err)
            ovr_d = 1'b0;
        // Completion on a transfer edge reloads; otherwise a busy register drops the word.
        if (final_byte) begin
            if (out_free) begin
                word_d  = completed;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign o_Word       = word_q;
    assign o_Word_Valid = valid_q;
    assign o_Overrun    = ovr_q;
    assign o_Timeout    = tmo_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor checks transfers.
module tb_uart_word_assembler;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic [31:0] o_Word;
    logic        o_Word_Valid;
    logic        i_Word_Ready;
    logic        o_Overrun;
    logic        o_Timeout;
    logic        i_Clear_Err;

    int total = 0;
    int bad   = 0;
    int tmo_cnt = 0;
    logic [31:0] exp_q[$];

    uart_word_assembler #(
        .WORD_BYTES   (4),
        .TIMEOUT_CLKS (3480)
    ) dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .o_Word       (o_Word),
        .o_Word_Valid (o_Word_Valid),
        .i_Word_Ready (i_Word_Ready),
        .o_Overrun    (o_Overrun),
        .o_Timeout    (o_Timeout),
        .i_Clear_Err  (i_Clear_Err)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge i_Clock) begin
        if (!i_Reset && o_Timeout)
            tmo_cnt++;
        if (!i_Reset && o_Word_Valid && i_Word_Ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got %h want none", o_Word);
            end else begin
                chk("mon_word", o_Word, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        tick(1);
        i_Rx_DV   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 3; i >= 0; i--) send(t[i*8 +: 8]);
    endtask

    int base;

    initial begin
        i_Reset = 1'b1; i_Rx_DV = 1'b0; i_Rx_Byte = '0;
        i_Word_Ready = 1'b0; i_Clear_Err = 1'b0;
        tick(2);
        i_Reset = 1'b0;
        chk("rst_word",  o_Word, 32'h0);
        chk("rst_valid", {31'b0, o_Word_Valid}, 32'h0);
        chk("rst_ovr",   {31'b0, o_Overrun}, 32'h0);
        chk("rst_tmo",   {31'b0, o_Timeout}, 32'h0);

        // 1: basic word, ready high
        i_Word_Ready = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        chk("t1_valid", {31'b0, o_Word_Valid}, 32'h1);
        chk("t1_word",  o_Word, 32'hDEADBEEF);
        tick(1);
        chk("t1_valid_fall", {31'b0, o_Word_Valid}, 32'h0);
        tick(2);

        // 2: hold while collecting next word
        i_Word_Ready = 1'b0;
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'h05060708);
        send_word(32'h01020304);
        chk("t2_valid", {31'b0, o_Word_Valid}, 32'h1);
        send(8'h05); send(8'h06); send(8'h07);
        chk("t2_hold", o_Word, 32'h01020304);
        i_Word_Ready = 1'b1;
        tick(1);
        i_Word_Ready = 1'b0;
        chk("t2_drained", {31'b0, o_Word_Valid}, 32'h0);
        send(8'h08);
        chk("t2_word2", o_Word, 32'h05060708);
        chk("t2_ovr",   {31'b0, o_Overrun}, 32'h0);
        i_Word_Ready = 1'b1;
        tick(1);
        chk("t2_empty", {31'b0, o_Word_Valid}, 32'h0);
        tick(2);

        // 3: overrun
        i_Word_Ready = 1'b0;
        exp_q.push_back(32'h11223344);
        send_word(32'h11223344);
        send_word(32'h55667788);
        chk("t3_word", o_Word, 32'h11223344);
        chk("t3_ovr",  {31'b0, o_Overrun}, 32'h1);
        tick(3);
        chk("t3_ovr_sticky", {31'b0, o_Overrun}, 32'h1);
        i_Clear_Err = 1'b1;
        tick(1);
        i_Clear_Err = 1'b0;
        chk("t3_ovr_clr", {31'b0, o_Overrun}, 32'h0);
        i_Word_Ready = 1'b1;
        tick(1);
        chk("t3_empty", {31'b0, o_Word_Valid}, 32'h0);
        tick(3);
        chk("t3_q_empty", exp_q.size(), 32'd0);

        // 4: timeout after two bytes
        base = tmo_cnt;
        send(8'hAA); send(8'hBB);
        tick(3479);
        chk("t4_tmo_early", {31'b0, o_Timeout}, 32'h0);
        tick(1);
        chk("t4_tmo_pulse", {31'b0, o_Timeout}, 32'h1);
        chk("t4_no_valid",  {31'b0, o_Word_Valid}, 32'h0);
        tick(1);
        chk("t4_tmo_fall", {31'b0, o_Timeout}, 32'h0);
        chk("t4_tmo_count", tmo_cnt - base, 32'd1);
        exp_q.push_back(32'h11223344);
        send_word(32'h11223344);
        chk("t4_word", o_Word, 32'h11223344);
        tick(3);

        // 5: byte on the expiry cycle wins
        base = tmo_cnt;
        exp_q.push_back(32'h12345678);
        send(8'h12);
        tick(3479);
        send(8'h34);
        chk("t5_no_tmo", {31'b0, o_Timeout}, 32'h0);
        send(8'h56); send(8'h78);
        chk("t5_word", o_Word, 32'h12345678);
        tick(3);
        chk("t5_tmo_count", tmo_cnt - base, 32'd0);

        // 6: reset mid-word
        base = tmo_cnt;
        send(8'h01); send(8'h02);
        i_Reset = 1'b1;
        tick(1);
        i_Reset = 1'b0;
        chk("t6_word",  o_Word, 32'h0);
        chk("t6_valid", {31'b0, o_Word_Valid}, 32'h0);
        chk("t6_ovr",   {31'b0, o_Overrun}, 32'h0);
        chk("t6_tmo",   {31'b0, o_Timeout}, 32'h0);
        exp_q.push_back(32'hCAFEBABE);
        send_word(32'hCAFEBABE);
        chk("t6_word2", o_Word, 32'hCAFEBABE);
        tick(4000);
        chk("t6_tmo_count", tmo_cnt - base, 32'd0);
        chk("final_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
